// File: rtl/formula_issuer_pkg.sv
// Shared types and constants for the formula argument issuer.
package formula_issuer_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    // One completed record as returned downstream.
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] a;
        logic [WIDTH_DEFAULT-1:0] b;
        logic [WIDTH_DEFAULT-1:0] c;
        logic [WIDTH_DEFAULT-1:0] res;
    } record_t;

endpackage

// File: rtl/issuer_ring_buffer.sv
// Record ring buffer with allocate (issue), fill (result) and free (drain) pointers.
module issuer_ring_buffer
    import formula_issuer_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEFAULT,
    parameter int unsigned depth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic [3*width-1:0]   alloc_data,
    input  logic                 fill,
    input  logic [width-1:0]     fill_data,
    input  logic                 free,
    output logic                 full,
    output logic                 has_done,
    output logic                 in_flight,
    output logic [4*width-1:0]   head
);

    localparam int unsigned addr_w = $clog2(depth);
    localparam int unsigned ptr_w  = addr_w + 1;

    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   res_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   occupancy;
    logic [3*width-1:0] abc_mem [depth];
    logic [width-1:0]   res_mem [depth];

    // Pointers advance independently; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            res_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (alloc) wr_ptr  <= wr_ptr + ptr_w'(1);
            if (fill)  res_ptr <= res_ptr + ptr_w'(1);
            if (free)  rd_ptr  <= rd_ptr + ptr_w'(1);
        end
    end

    // Arguments and results land in separate arrays so both can write in one cycle.
    always_ff @(posedge clk) begin
        if (alloc) abc_mem[wr_ptr[addr_w-1:0]] <= alloc_data;
        if (fill)  res_mem[res_ptr[addr_w-1:0]] <= fill_data;
    end

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == ptr_w'(depth));
    assign in_flight = (res_ptr != wr_ptr);
    assign has_done  = (rd_ptr != res_ptr);
    assign head      = {abc_mem[rd_ptr[addr_w-1:0]], res_mem[rd_ptr[addr_w-1:0]]};

endmodule

// File: rtl/formula_issuer.sv
// Issues (a, b, c) triples to a formula pipe and returns {a, b, c, res} records in order.
module formula_issuer
    import formula_issuer_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEFAULT,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [width-1:0] up_a,
    input  logic [width-1:0] up_b,
    input  logic [width-1:0] up_c,
    output logic             arg_vld,
    output logic [width-1:0] a,
    output logic [width-1:0] b,
    output logic [width-1:0] c,
    input  logic             res_vld,
    input  logic [width-1:0] res,
    output logic             dn_vld,
    input  logic             dn_rdy,
    output logic [width-1:0] dn_a,
    output logic [width-1:0] dn_b,
    output logic [width-1:0] dn_c,
    output logic [width-1:0] dn_res,
    output logic             err
);

    logic               full;
    logic               has_done;
    logic               in_flight;
    logic               up_fire;
    logic               fill;
    logic               free;
    logic [4*width-1:0] head;

    // A slot is reserved at issue time, so a full buffer blocks upstream.
    assign up_rdy  = !full;
    assign up_fire = up_vld & up_rdy;
    assign fill    = res_vld & in_flight;
    assign free    = has_done & dn_rdy;

    issuer_ring_buffer #(
        .width (width),
        .depth (depth)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .alloc      (up_fire),
        .alloc_data ({up_a, up_b, up_c}),
        .fill       (fill),
        .fill_data  (res),
        .free       (free),
        .full       (full),
        .has_done   (has_done),
        .in_flight  (in_flight),
        .head       (head)
    );

    // Argument registers and the sticky unexpected-result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_vld <= 1'b0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            err     <= 1'b0;
        end else begin
            arg_vld <= up_fire;
            if (up_fire) begin
                a <= up_a;
                b <= up_b;
                c <= up_c;
            end
            if (res_vld && !in_flight) err <= 1'b1;
        end
    end

    assign dn_vld = has_done;
    assign {dn_a, dn_b, dn_c, dn_res} = head;

endmodule
